velocity_digit_converter: RTL and testbench

Converts one car's signed fixed-point velocity vector into three BCD digits (hundred/ten/one) with leading-zero blanking, for the status-bar velocity digit renderer. Runs once per frame on a start pulse from the physics update, as a multi-cycle sequential binary-to-BCD converter with a start/valid handshake. One instance per car. Outputs hold between conversions so the renderer can read them at any pixel.

---
 rtl/velocity_digit_converter.sv | 245 ++++++++++++++++++++++++
 tb/tb_velocity_digit_converter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/velocity_digit_converter.sv
// -----------------------------------------------------------------------------
// velocity_digit_converter
//
// Turns one car's signed Q4.6 velocity vector into three BCD digits for the
// status-bar speed readout. The conversion is multi-cycle:
//   IDLE -> MAG -> SCALE -> CONVERT (10 cycles) -> DONE -> IDLE
// That is 12 clock edges from the accepted start edge to the o_valid cycle.
//
// The magnitude is the usual octagonal estimate max + min/2. It is scaled to
// display units and clamped to DISPLAY_MAX. A double-dabble shifter then
// produces the BCD digits. Digit and flag outputs are registered. They change
// only at the edge entering DONE, so the renderer can sample them at any time.
//
// Ports:
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_start          one-cycle convert request (dropped while o_busy=1)
//   i_vel_x/i_vel_y  signed Q4.6 velocity components
//   o_busy           high in every state except IDLE
//   o_valid          one-cycle pulse while in DONE
//   o_hundred/o_ten/o_one  BCD digits of the displayed speed
//   o_blank_hundred  hundreds digit is a leading zero
//   o_blank_ten      tens digit is a leading zero
//   o_saturated      last result was clamped to DISPLAY_MAX
// -----------------------------------------------------------------------------
module velocity_digit_converter #(
    parameter int VEL_WIDTH     = 10,
    parameter int FRAC_WIDTH    = 6,
    parameter int DISPLAY_SCALE = 100,
    parameter int DISPLAY_MAX   = 999
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [VEL_WIDTH-1:0] i_vel_x,
    input  logic [VEL_WIDTH-1:0] i_vel_y,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [3:0]           o_hundred,
    output logic [3:0]           o_ten,
    output logic [3:0]           o_one,
    output logic                 o_blank_hundred,
    output logic                 o_blank_ten,
    output logic                 o_saturated
);

    localparam int MAG_W  = VEL_WIDTH + 1;
    localparam int PROD_W = MAG_W + $clog2(DISPLAY_SCALE + 1);
    localparam int BIN_W  = 10;
    localparam int BCD_W  = 12;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MAG     = 3'd1,
        S_SCALE   = 3'd2,
        S_CONVERT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [VEL_WIDTH-1:0]  r_vel_x;
    logic [VEL_WIDTH-1:0]  r_vel_y;
    logic [MAG_W-1:0]      r_mag;
    logic [BIN_W-1:0]      r_bin;
    logic [BCD_W-1:0]      r_bcd;
    logic [3:0]            r_cnt;
    logic                  r_sat_pend;
    logic [3:0]            r_hundred;
    logic [3:0]            r_ten;
    logic [3:0]            r_one;
    logic                  r_blank_hundred;
    logic                  r_blank_ten;
    logic                  r_saturated;

    logic [VEL_WIDTH-1:0]   w_ax;
    logic [VEL_WIDTH-1:0]   w_ay;
    logic [VEL_WIDTH-1:0]   w_max;
    logic [VEL_WIDTH-1:0]   w_min;
    logic [MAG_W-1:0]       w_mag;
    logic [PROD_W-1:0]      w_prod;
    logic [PROD_W-1:0]      w_val;
    logic                   w_over;
    logic [BIN_W-1:0]       w_bin_load;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic [BCD_W+BIN_W-1:0] w_shift;
    logic [BCD_W-1:0]       w_bcd_next;
    logic [BIN_W-1:0]       w_bin_next;

    // Double-dabble correction for one BCD nibble.
    function automatic logic [3:0] nibble_adjust(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

    // Double-dabble correction across the whole three-digit accumulator.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        return {nibble_adjust(b[11:8]), nibble_adjust(b[7:4]), nibble_adjust(b[3:0])};
    endfunction

    // Datapath: |v| (the unsigned view makes -512 become 512), magnitude estimate,
    // scaling with clamping, and one double-dabble step.
    always_comb begin
        if (r_vel_x[VEL_WIDTH-1]) begin
            w_ax = ~r_vel_x + VEL_WIDTH'(1);
        end else begin
            w_ax = r_vel_x;
        end
        if (r_vel_y[VEL_WIDTH-1]) begin
            w_ay = ~r_vel_y + VEL_WIDTH'(1);
        end else begin
            w_ay = r_vel_y;
        end
        if (w_ax >= w_ay) begin
            w_max = w_ax;
            w_min = w_ay;
        end else begin
            w_max = w_ay;
            w_min = w_ax;
        end
        w_mag      = MAG_W'(w_max) + MAG_W'(w_min >> 1);
        w_prod     = PROD_W'(r_mag) * PROD_W'(DISPLAY_SCALE);
        w_val      = w_prod >> FRAC_WIDTH;
        w_over     = (w_val > PROD_W'(DISPLAY_MAX));
        if (w_over) begin
            w_bin_load = BIN_W'(DISPLAY_MAX);
        end else begin
            w_bin_load = w_val[BIN_W-1:0];
        end
        w_bcd_adj  = bcd_adjust(r_bcd);
        w_shift    = {w_bcd_adj, r_bin} << 1;
        w_bcd_next = w_shift[BCD_W+BIN_W-1:BIN_W];
        w_bin_next = w_shift[BIN_W-1:0];
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_MAG;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_MAG:   w_state_next = S_SCALE;
            S_SCALE: w_state_next = S_CONVERT;
            S_CONVERT: begin
                if (r_cnt == 4'd9) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_CONVERT;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the state register.
    always_comb begin
        o_busy  = (r_state != S_IDLE);
        o_valid = (r_state == S_DONE);
    end

    // Conversion datapath registers and the held result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vel_x         <= '0;
            r_vel_y         <= '0;
            r_mag           <= '0;
            r_bin           <= '0;
            r_bcd           <= '0;
            r_cnt           <= 4'd0;
            r_sat_pend      <= 1'b0;
            r_hundred       <= 4'd0;
            r_ten           <= 4'd0;
            r_one           <= 4'd0;
            r_blank_hundred <= 1'b1;
            r_blank_ten     <= 1'b1;
            r_saturated     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_vel_x <= i_vel_x;
                        r_vel_y <= i_vel_y;
                    end
                end
                S_MAG: begin
                    r_mag <= w_mag;
                end
                S_SCALE: begin
                    r_bin      <= w_bin_load;
                    r_sat_pend <= w_over;
                    r_bcd      <= '0;
                    r_cnt      <= 4'd0;
                end
                S_CONVERT: begin
                    r_bin <= w_bin_next;
                    r_bcd <= w_bcd_next;
                    r_cnt <= r_cnt + 4'd1;
                    // The last iteration's result goes straight to the outputs.
                    if (r_cnt == 4'd9) begin
                        r_hundred       <= w_bcd_next[11:8];
                        r_ten           <= w_bcd_next[7:4];
                        r_one           <= w_bcd_next[3:0];
                        r_blank_hundred <= (w_bcd_next[11:8] == 4'd0);
                        r_blank_ten     <= (w_bcd_next[11:4] == 8'd0);
                        r_saturated     <= r_sat_pend;
                    end
                end
                S_DONE: begin
                    r_cnt <= 4'd0;
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign o_hundred       = r_hundred;
    assign o_ten           = r_ten;
    assign o_one           = r_one;
    assign o_blank_hundred = r_blank_hundred;
    assign o_blank_ten     = r_blank_ten;
    assign o_saturated     = r_saturated;

endmodule

// File: tb/tb_velocity_digit_converter.sv
// -----------------------------------------------------------------------------
// Testbench for velocity_digit_converter. It applies a table of directed
// vectors with hand-computed digits. It then runs hand-written sequences for
// dropped starts, back-to-back acceptance, and reset during a conversion.
// -----------------------------------------------------------------------------
module tb_velocity_digit_converter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] vel_x;
    logic [9:0] vel_y;
    logic       busy;
    logic       valid;
    logic [3:0] hundred;
    logic [3:0] ten;
    logic [3:0] one;
    logic       blank_hundred;
    logic       blank_ten;
    logic       saturated;

    int n_cmp;
    int n_bad;

    velocity_digit_converter dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_vel_x         (vel_x),
        .i_vel_y         (vel_y),
        .o_busy          (busy),
        .o_valid         (valid),
        .o_hundred       (hundred),
        .o_ten           (ten),
        .o_one           (one),
        .o_blank_hundred (blank_hundred),
        .o_blank_ten     (blank_ten),
        .o_saturated     (saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] vx;
        logic [9:0] vy;
        int         h;
        int         t;
        int         o;
        int         bh;
        int         bt;
        int         sat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input int h, input int t, input int o,
                                input int bh, input int bt, input int sat);
        check({tag, ".hundred"}, int'(hundred), h);
        check({tag, ".ten"}, int'(ten), t);
        check({tag, ".one"}, int'(one), o);
        check({tag, ".blank_hundred"}, int'(blank_hundred), bh);
        check({tag, ".blank_ten"}, int'(blank_ten), bt);
        check({tag, ".saturated"}, int'(saturated), sat);
    endtask

    // Pulse start so that it is sampled at the next edge (edge k). On return we
    // are 1 time unit after edge k. The inputs are then scrambled to show that
    // only the start edge samples them.
    task automatic pulse_start(input logic [9:0] vx, input logic [9:0] vy);
        vel_x = vx;
        vel_y = vy;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        vel_x = ~vx;
        vel_y = vx ^ 10'h155;
    endtask

    // Count edges after edge k until o_valid rises; 40 is the timeout value.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int nvalid;
        int v_edge[2];

        n_cmp = 0;
        n_bad = 0;
        start = 1'b0;
        vel_x = 10'd0;
        vel_y = 10'd0;

        //            vx       vy       h  t  o  bh bt sat
        vecs[0] = '{10'd64,  10'd0,   1, 0, 0, 0, 0, 0};  // +1.0 -> 100
        vecs[1] = '{10'h200, 10'd0,   8, 0, 0, 0, 0, 0};  // -8.0 -> 800
        vecs[2] = '{10'd32,  10'h3F0, 0, 6, 2, 1, 0, 0};  // mag 40 -> 62
        vecs[3] = '{10'h200, 10'h200, 9, 9, 9, 0, 0, 1};  // mag 768 -> 1200, clamp
        vecs[4] = '{10'd0,   10'd0,   0, 0, 0, 1, 1, 0};  // zero
        vecs[5] = '{10'd100, 10'h3DB, 1, 8, 4, 0, 0, 0};  // 100,-37: mag 118 -> 184
        vecs[6] = '{10'd5,   10'd3,   0, 0, 9, 1, 1, 0};  // mag 6 -> 9
        vecs[7] = '{10'd511, 10'd256, 9, 9, 8, 0, 0, 0};  // mag 639 -> 998
        vecs[8] = '{10'd511, 10'd258, 9, 9, 9, 0, 0, 1};  // mag 640 -> 1000, clamp
        vecs[9] = '{10'd0,   10'h3F6, 0, 1, 5, 1, 0, 0};  // mag 10 -> 15

        // Reset state.
        rst_n = 1'b0;
        #12;
        check("reset.busy", int'(busy), 0);
        check("reset.valid", int'(valid), 0);
        check_result("reset", 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven conversions.
        for (int i = 0; i < 10; i++) begin
            pulse_start(vecs[i].vx, vecs[i].vy);
            check($sformatf("vec%0d.busy", i), int'(busy), 1);
            wait_valid(lat);
            check($sformatf("vec%0d.latency", i), lat, 12);
            check_result($sformatf("vec%0d", i), vecs[i].h, vecs[i].t, vecs[i].o,
                         vecs[i].bh, vecs[i].bt, vecs[i].sat);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.valid_pulse", i), int'(valid), 0);
            check($sformatf("vec%0d.idle", i), int'(busy), 0);
            repeat (3) @(posedge clk);
            #1;
            check_result($sformatf("vec%0d.hold", i), vecs[i].h, vecs[i].t, vecs[i].o,
                         vecs[i].bh, vecs[i].bt, vecs[i].sat);
        end

        // Starts sampled at k+5, k+12 and in the DONE cycle (k+13) are dropped.
        pulse_start(10'd64, 10'd0);
        nvalid = 0;
        for (int e = 1; e <= 40; e++) begin
            start = (e == 5 || e == 12 || e == 13);
            vel_x = 10'h200;
            vel_y = 10'h200;
            @(posedge clk);
            #1;
            if (valid) nvalid++;
        end
        start = 1'b0;
        check("drop.valid_count", nvalid, 1);
        check_result("drop", 1, 0, 0, 0, 0, 0);

        // The first start seen with o_busy low again is accepted (edge k+14).
        pulse_start(10'd64, 10'd0);
        nvalid = 0;
        v_edge[0] = -1;
        v_edge[1] = -1;
        for (int e = 1; e <= 45; e++) begin
            start = (e == 14);
            vel_x = 10'd0;
            vel_y = 10'h3F6;
            @(posedge clk);
            #1;
            if (valid) begin
                if (nvalid < 2) v_edge[nvalid] = e;
                nvalid++;
            end
        end
        start = 1'b0;
        check("b2b.valid_count", nvalid, 2);
        check("b2b.first_edge", v_edge[0], 12);
        check("b2b.second_edge", v_edge[1], 26);
        check_result("b2b", 0, 1, 5, 1, 0, 0);

        // Reset at k+6, during CONVERT, aborts the conversion without a valid pulse.
        pulse_start(10'h200, 10'd0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.busy", int'(busy), 0);
        check("abort.valid", int'(valid), 0);
        check_result("abort", 0, 0, 0, 1, 1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (valid) nvalid++;
        end
        check("abort.no_valid", nvalid, 0);
        check_result("abort.hold", 0, 0, 0, 1, 1, 0);

        // A fresh conversion after reset release works.
        pulse_start(10'd100, 10'h3DB);
        wait_valid(lat);
        check("post_reset.latency", lat, 12);
        check_result("post_reset", 1, 8, 4, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
